// File: rtl/jzjpcc_pc_ras_if.sv
// Fetch-PC / RAS interface: control inputs from fetch/execute and PC outputs for the IMEM path.
// The master modport is the driver of fetch control; the slave modport is the PC block itself.
interface jzjpcc_pc_ras_if #(
    parameter int PC_MAX_B  = 31,
    parameter int RAS_DEPTH = 4
);
    logic                          stall_fetch;
    logic                          redirect_valid;
    logic [PC_MAX_B:2]             redirect_pc;
    logic                          predict_call;
    logic                          predict_return;
    logic [PC_MAX_B:2]             call_target;
    logic                          ras_flush;
    logic [PC_MAX_B:2]             currentPC_fetch;
    logic [PC_MAX_B:2]             nextPC;
    logic                          predicted_return;
    logic [$clog2(RAS_DEPTH):0]    ras_count;

    modport master (
        output stall_fetch, redirect_valid, redirect_pc, predict_call,
               predict_return, call_target, ras_flush,
        input  currentPC_fetch, nextPC, predicted_return, ras_count
    );

    modport slave (
        input  stall_fetch, redirect_valid, redirect_pc, predict_call,
               predict_return, call_target, ras_flush,
        output currentPC_fetch, nextPC, predicted_return, ras_count
    );
endinterface

// File: rtl/jzjpcc_pc_ras.sv
// Fetch-stage PC with configurable reset vector and circular return-address stack.
// The RAS is built only when JZJPCC_RAS_EN is defined; without it, calls still steer to call_target.
module jzjpcc_pc_ras #(
    parameter int PC_MAX_B     = 31,
    parameter int RESET_VECTOR = 0,
    parameter int RAS_DEPTH    = 4
) (
    input logic            clock,
    input logic            reset_n,
    jzjpcc_pc_ras_if.slave bus
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;
    typedef logic [PC_MAX_B:2] pc_t;

    pc_t r_pc;
    pc_t w_seq;
    pc_t w_next;

    assign w_seq = r_pc + pc_t'(1);

`ifdef JZJPCC_RAS_EN
    localparam int AW = $clog2(RAS_DEPTH);
    typedef logic [AW-1:0] idx_t;
    typedef logic [CW-1:0] cnt_t;

    pc_t  r_ras [RAS_DEPTH];
    idx_t r_tp;
    cnt_t r_cnt;
    idx_t w_top_idx;
    logic w_pop;
    logic w_push;
    logic w_upd;
    logic w_pred_ret;

    assign w_top_idx = r_tp - idx_t'(1);
    assign w_pop     = bus.predict_return && (r_cnt != '0);
    assign w_push    = bus.predict_call;
    // Redirects never touch the stack; a flush takes precedence over push/pop.
    assign w_upd     = !bus.stall_fetch && !bus.redirect_valid && !bus.ras_flush;

    always_comb begin
        w_next     = w_seq;
        w_pred_ret = 1'b0;
        if (bus.redirect_valid) begin
            w_next = bus.redirect_pc;
        end else if (w_pop) begin
            w_next     = r_ras[w_top_idx];
            w_pred_ret = 1'b1;
        end else if (bus.predict_call) begin
            w_next = bus.call_target;
        end
    end

    // Entry storage has no reset; validity is tracked entirely by r_cnt.
    always_ff @(posedge clock) begin
        if (w_upd && w_push) begin
            if (w_pop) begin
                r_ras[w_top_idx] <= w_seq;
            end else begin
                r_ras[r_tp] <= w_seq;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tp  <= '0;
            r_cnt <= '0;
        end else if (!bus.stall_fetch && bus.ras_flush) begin
            r_cnt <= '0;
        end else if (w_upd) begin
            if (w_push && !w_pop) begin
                // Full stack wraps onto the oldest entry; count saturates.
                r_tp <= r_tp + idx_t'(1);
                if (r_cnt != cnt_t'(RAS_DEPTH)) begin
                    r_cnt <= r_cnt + cnt_t'(1);
                end
            end else if (w_pop && !w_push) begin
                r_tp  <= w_top_idx;
                r_cnt <= r_cnt - cnt_t'(1);
            end
        end
    end

    assign bus.predicted_return = w_pred_ret;
    assign bus.ras_count        = r_cnt;
`else
    logic w_unused_ok;
    assign w_unused_ok = bus.predict_return ^ bus.ras_flush;

    always_comb begin
        w_next = w_seq;
        if (bus.redirect_valid) begin
            w_next = bus.redirect_pc;
        end else if (bus.predict_call) begin
            w_next = bus.call_target;
        end
    end

    assign bus.predicted_return = 1'b0;
    assign bus.ras_count        = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= pc_t'(RESET_VECTOR);
        end else if (!bus.stall_fetch) begin
            r_pc <= w_next;
        end
    end

    assign bus.currentPC_fetch = r_pc;
    assign bus.nextPC          = w_next;
endmodule

// File: tb/tb_jzjpcc_pc_ras.sv
// Scoreboard bench for jzjpcc_pc_ras: directed steps queue expected PC/RAS values, a monitor compares.
// Expectations follow the JZJPCC_RAS_EN build setting.
module tb_jzjpcc_pc_ras;
    typedef logic [31:2] pc_t;

`ifdef JZJPCC_RAS_EN
    localparam bit R = 1'b1;
`else
    localparam bit R = 1'b0;
`endif

    typedef struct {
        int  cyc;
        bit  ph;    // 0: sampled mid low phase, 1: sampled just after rising edge
        bit  kind;  // 0: nextPC/predicted_return, 1: currentPC_fetch/ras_count
        pc_t a;
        int  b;
    } exp_t;

    logic  clock = 1'b0;
    logic  reset_n = 1'b0;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    exp_t  q[$];
    string nq[$];

    jzjpcc_pc_ras_if #(.PC_MAX_B(31), .RAS_DEPTH(4)) bus ();

    jzjpcc_pc_ras #(
        .PC_MAX_B    (31),
        .RESET_VECTOR('h40),
        .RAS_DEPTH   (4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic push(input string nm, input int c, input bit ph, input bit kind, input pc_t a, input int b);
        exp_t e;
        e.cyc = c; e.ph = ph; e.kind = kind; e.a = a; e.b = b;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic drain(input bit ph);
        exp_t  e;
        string nm;
        while (q.size() > 0 && q[0].cyc == cyc && q[0].ph == ph) begin
            e  = q.pop_front();
            nm = nq.pop_front();
            checks++;
            if (e.kind == 1'b0) begin
                if (bus.nextPC !== e.a || int'(bus.predicted_return) != e.b) begin
                    failures++;
                    $display("FAIL %s: got nextPC=%h pred=%0d, want nextPC=%h pred=%0d",
                             nm, bus.nextPC, bus.predicted_return, e.a, e.b);
                end
            end else begin
                if (bus.currentPC_fetch !== e.a || int'(bus.ras_count) != e.b) begin
                    failures++;
                    $display("FAIL %s: got pc=%h count=%0d, want pc=%h count=%0d",
                             nm, bus.currentPC_fetch, bus.ras_count, e.a, e.b);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            #2;
            drain(1'b0);
            @(posedge clock);
            #1;
            drain(1'b1);
        end
    end

    task automatic step(input string nm, input bit st, input bit rv, input pc_t rpc,
                        input bit call, input bit ret, input pc_t ct, input bit fl,
                        input pc_t e_next, input int e_pred, input pc_t e_pc, input int e_cnt);
        @(negedge clock);
        reset_n            = 1'b1;
        bus.stall_fetch    = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.predict_call   = call;
        bus.predict_return = ret;
        bus.call_target    = ct;
        bus.ras_flush      = fl;
        push({nm, "_comb"}, cyc, 1'b0, 1'b0, e_next, e_pred);
        push({nm, "_state"}, cyc + 1, 1'b1, 1'b1, e_pc, e_cnt);
    endtask

    task automatic do_reset(input string nm, input bit st);
        @(negedge clock);
        bus.stall_fetch    = st;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.predict_call   = 1'b0;
        bus.predict_return = 1'b0;
        bus.call_target    = '0;
        bus.ras_flush      = 1'b0;
        reset_n            = 1'b0;
        push({nm, "_state"}, cyc, 1'b0, 1'b1, 'h40, 0);
        push({nm, "_comb"}, cyc, 1'b0, 1'b0, 'h41, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall_fetch    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.predict_call   = 1'b0;
        bus.predict_return = 1'b0;
        bus.call_target    = '0;
        bus.ras_flush      = 1'b0;

        do_reset("reset_init", 1'b0);
        //    name         st rv rpc    call ret ct     fl  next                  pred     pc                    cnt
        step("release",    0, 0, 0,     0,   0,  0,     0,  'h41,                 0,       'h41,                 0);
        step("redir0",     0, 1, 0,     0,   0,  0,     0,  0,                    0,       0,                    0);
        step("seq1",       0, 0, 0,     0,   0,  0,     0,  1,                    0,       1,                    0);
        step("seq2",       0, 0, 0,     0,   0,  0,     0,  2,                    0,       2,                    0);
        step("seq3",       0, 0, 0,     0,   0,  0,     0,  3,                    0,       3,                    0);
        step("stall1",     1, 0, 0,     0,   0,  0,     0,  4,                    0,       3,                    0);
        step("stall2",     1, 0, 0,     0,   0,  0,     0,  4,                    0,       3,                    0);
        // call then return
        step("cr_redir",   0, 1, 'h10,  0,   0,  0,     0,  'h10,                 0,       'h10,                 0);
        step("cr_call",    0, 0, 0,     1,   0,  'h80,  0,  'h80,                 0,       'h80,                 int'(R));
        step("cr_ret",     0, 0, 0,     0,   1,  0,     0,  R ? 'h11 : 'h81,      int'(R), R ? 'h11 : 'h81,      0);
        step("cr_retmt",   0, 0, 0,     0,   1,  0,     0,  R ? 'h12 : 'h82,      0,       R ? 'h12 : 'h82,      0);
        // overflow: five nested calls into a four-entry stack
        step("ov_redir",   0, 1, 'h10,  0,   0,  0,     0,  'h10,                 0,       'h10,                 0);
        step("ov_call1",   0, 0, 0,     1,   0,  'h20,  0,  'h20,                 0,       'h20,                 R ? 1 : 0);
        step("ov_call2",   0, 0, 0,     1,   0,  'h30,  0,  'h30,                 0,       'h30,                 R ? 2 : 0);
        step("ov_call3",   0, 0, 0,     1,   0,  'h40,  0,  'h40,                 0,       'h40,                 R ? 3 : 0);
        step("ov_call4",   0, 0, 0,     1,   0,  'h50,  0,  'h50,                 0,       'h50,                 R ? 4 : 0);
        step("ov_call5",   0, 0, 0,     1,   0,  'h60,  0,  'h60,                 0,       'h60,                 R ? 4 : 0);
        step("ov_ret1",    0, 0, 0,     0,   1,  0,     0,  R ? 'h51 : 'h61,      int'(R), R ? 'h51 : 'h61,      R ? 3 : 0);
        step("ov_ret2",    0, 0, 0,     0,   1,  0,     0,  R ? 'h41 : 'h62,      int'(R), R ? 'h41 : 'h62,      R ? 2 : 0);
        step("ov_ret3",    0, 0, 0,     0,   1,  0,     0,  R ? 'h31 : 'h63,      int'(R), R ? 'h31 : 'h63,      R ? 1 : 0);
        step("ov_ret4",    0, 0, 0,     0,   1,  0,     0,  R ? 'h21 : 'h64,      int'(R), R ? 'h21 : 'h64,      0);
        step("ov_ret5",    0, 0, 0,     0,   1,  0,     0,  R ? 'h22 : 'h65,      0,       R ? 'h22 : 'h65,      0);
        // redirect beats call and return, stack untouched
        step("pr_redir",   0, 1, 'h10,  0,   0,  0,     0,  'h10,                 0,       'h10,                 0);
        step("pr_call1",   0, 0, 0,     1,   0,  'h20,  0,  'h20,                 0,       'h20,                 R ? 1 : 0);
        step("pr_call2",   0, 0, 0,     1,   0,  'h30,  0,  'h30,                 0,       'h30,                 R ? 2 : 0);
        step("pr_all",     0, 1, 'h200, 1,   1,  'h99,  0,  'h200,                0,       'h200,                R ? 2 : 0);
        step("pr_ret",     0, 0, 0,     0,   1,  0,     0,  R ? 'h21 : 'h201,     int'(R), R ? 'h21 : 'h201,     R ? 1 : 0);
        step("cr_both",    0, 0, 0,     1,   1,  'h70,  0,  R ? 'h11 : 'h70,      int'(R), R ? 'h11 : 'h70,      R ? 1 : 0);
        step("cr_both_r",  0, 0, 0,     0,   1,  0,     0,  R ? 'h22 : 'h71,      int'(R), R ? 'h22 : 'h71,      0);
        // flush overrides a same-cycle push
        step("fl_redir",   0, 1, 'h10,  0,   0,  0,     0,  'h10,                 0,       'h10,                 0);
        step("fl_call",    0, 0, 0,     1,   0,  'h80,  0,  'h80,                 0,       'h80,                 R ? 1 : 0);
        step("fl_flush",   0, 0, 0,     1,   0,  'h90,  1,  'h90,                 0,       'h90,                 0);
        step("fl_ret",     0, 0, 0,     0,   1,  0,     0,  'h91,                 0,       'h91,                 0);
        step("mt_both",    0, 0, 0,     1,   1,  'hA0,  0,  'hA0,                 0,       'hA0,                 R ? 1 : 0);
        step("mt_ret",     0, 0, 0,     0,   1,  0,     0,  R ? 'h92 : 'hA1,      int'(R), R ? 'h92 : 'hA1,      0);
        // stalls hold PC and stack while nextPC still reflects inputs
        step("st_call",    1, 0, 0,     1,   0,  'hB0,  0,  'hB0,                 0,       R ? 'h92 : 'hA1,      0);
        step("st_redir",   1, 1, 'h300, 0,   0,  0,     0,  'h300,                0,       R ? 'h92 : 'hA1,      0);
        step("rs_call",    0, 0, 0,     1,   0,  'hC0,  0,  'hC0,                 0,       'hC0,                 R ? 1 : 0);
        step("rs_stall",   1, 0, 0,     0,   0,  0,     0,  'hC1,                 0,       'hC0,                 R ? 1 : 0);
        do_reset("reset_mid", 1'b1);
        step("rs_release", 0, 0, 0,     0,   0,  0,     0,  'h41,                 0,       'h41,                 0);
        step("rs_retmt",   0, 0, 0,     0,   1,  0,     0,  'h42,                 0,       'h42,                 0);
        // sequential increment wraps at the top of the PC range
        step("wr_redir",   0, 1, 'h3FFFFFFF, 0, 0, 0,   0,  'h3FFFFFFF,           0,       'h3FFFFFFF,           0);
        step("wr_seq",     0, 0, 0,     0,   0,  0,     0,  0,                    0,       0,                    0);

        @(negedge clock);
        bus.redirect_valid = 1'b0;
        bus.predict_call   = 1'b0;
        bus.predict_return = 1'b0;
        bus.stall_fetch    = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
